// File: rtl/boot_pkg.sv
// Shared definitions for the instruction-memory boot loader: FSM states,
// instruction width and the default frame start marker.
package boot_pkg;

  localparam int         INSTR_W      = 16;
  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA_HI,
    S_DATA_LO,
    S_WRITE,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

endpackage

// File: rtl/boot_word_asm.sv
// Pairs HI/LO payload bytes into a big-endian instruction word and keeps the
// running XOR checksum of every byte after the sync marker.
module boot_word_asm
  import boot_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               i_clear,
  input  logic               i_en,
  input  logic               i_hi_en,
  input  logic               i_lo_en,
  input  logic [7:0]         i_byte,
  output logic [INSTR_W-1:0] o_word,
  output logic [7:0]         o_chk
);

  logic [7:0] r_hi;
  logic [7:0] r_lo;
  logic [7:0] r_acc;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hi  <= '0;
      r_lo  <= '0;
      r_acc <= '0;
    end else begin
      if (i_clear)   r_acc <= '0;
      else if (i_en) r_acc <= r_acc ^ i_byte;
      if (i_hi_en)   r_hi  <= i_byte;
      if (i_lo_en)   r_lo  <= i_byte;
    end
  end

  assign o_word = {r_hi, r_lo};
  assign o_chk  = r_acc;

endmodule

// File: rtl/imem_boot_loader.sv
// Frame receiver that writes 16-bit instructions into imem and releases the
// core only after a complete image with a matching checksum has been loaded.
module imem_boot_loader
  import boot_pkg::*;
#(
  parameter int         ADDR_W    = 8,
  parameter logic [7:0] SYNC_BYTE = SYNC_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic               rx_ready,
  output logic               imem_we,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic [INSTR_W-1:0] imem_wdata,
  output logic               cpu_run,
  output logic               load_err,
  output logic [ADDR_W:0]    words_loaded
);

  localparam int LEN_W = ADDR_W + 1;

  state_t r_state;
  state_t w_next;

  logic [7:0]         r_len_hi;
  logic [LEN_W-1:0]   r_len;
  logic [LEN_W-1:0]   r_words;
  logic               r_cpu_run;
  logic               r_load_err;

  logic               w_accept;
  logic               w_is_sync;
  logic [15:0]        w_len_full;
  logic               w_len_bad;
  logic               w_last_word;
  logic               w_start;
  logic               w_acc_en;
  logic               w_len_hi_en;
  logic               w_len_lo_en;
  logic               w_hi_en;
  logic               w_lo_en;
  logic               w_write;
  logic               w_chk_ok;
  logic               w_set_err;
  logic [INSTR_W-1:0] w_word;
  logic [7:0]         w_chk;

  assign rx_ready    = !rst && (r_state != S_WRITE);
  assign w_accept    = rx_valid && rx_ready;
  assign w_is_sync   = (rx_data == SYNC_BYTE);
  assign w_len_full  = {r_len_hi, rx_data};
  assign w_len_bad   = 32'(w_len_full) > (32'd1 << ADDR_W);
  assign w_last_word = (r_words + LEN_W'(1)) == r_len;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    w_next      = r_state;
    w_start     = 1'b0;
    w_acc_en    = 1'b0;
    w_len_hi_en = 1'b0;
    w_len_lo_en = 1'b0;
    w_hi_en     = 1'b0;
    w_lo_en     = 1'b0;
    w_write     = 1'b0;
    w_chk_ok    = 1'b0;
    w_set_err   = 1'b0;
    case (r_state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (w_accept && w_is_sync) begin
          w_start = 1'b1;
          w_next  = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (w_accept) begin
          w_acc_en    = 1'b1;
          w_len_hi_en = 1'b1;
          w_next      = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (w_accept) begin
          w_acc_en    = 1'b1;
          w_len_lo_en = 1'b1;
          if (w_len_bad) begin
            w_set_err = 1'b1;
            w_next    = S_ERROR;
          end else if (w_len_full == '0) begin
            w_next = S_CHECK;
          end else begin
            w_next = S_DATA_HI;
          end
        end
      end
      S_DATA_HI: begin
        if (w_accept) begin
          w_acc_en = 1'b1;
          w_hi_en  = 1'b1;
          w_next   = S_DATA_LO;
        end
      end
      S_DATA_LO: begin
        if (w_accept) begin
          w_acc_en = 1'b1;
          w_lo_en  = 1'b1;
          w_next   = S_WRITE;
        end
      end
      S_WRITE: begin
        w_write = 1'b1;
        w_next  = w_last_word ? S_CHECK : S_DATA_HI;
      end
      S_CHECK: begin
        if (w_accept) begin
          if (rx_data == w_chk) begin
            w_chk_ok = 1'b1;
            w_next   = S_DONE;
          end else begin
            w_set_err = 1'b1;
            w_next    = S_ERROR;
          end
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_len_hi   <= '0;
      r_len      <= '0;
      r_words    <= '0;
      r_cpu_run  <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      if (w_start) begin
        r_words    <= '0;
        r_cpu_run  <= 1'b0;
        r_load_err <= 1'b0;
      end
      if (w_len_hi_en) r_len_hi   <= rx_data;
      // Only lengths that passed the capacity check are used, so LEN_W bits suffice.
      if (w_len_lo_en) r_len      <= LEN_W'(w_len_full);
      if (w_write)     r_words    <= r_words + LEN_W'(1);
      if (w_chk_ok)    r_cpu_run  <= 1'b1;
      if (w_set_err)   r_load_err <= 1'b1;
    end
  end

  boot_word_asm u_word_asm (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_start),
    .i_en    (w_acc_en),
    .i_hi_en (w_hi_en),
    .i_lo_en (w_lo_en),
    .i_byte  (rx_data),
    .o_word  (w_word),
    .o_chk   (w_chk)
  );

  assign imem_we      = (r_state == S_WRITE);
  assign imem_addr    = imem_we ? r_words[ADDR_W-1:0] : '0;
  assign imem_wdata   = imem_we ? w_word : '0;
  assign cpu_run      = r_cpu_run;
  assign load_err     = r_load_err;
  assign words_loaded = r_words;

endmodule
